// File: rtl/day1_pkg.sv
// Shared constants and FSM state type for the Day 1 stream sequencer.
package day1_pkg;

    localparam int unsigned MAG_W_DEF = 16;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StDir,
        StNum,
        StDrain,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/day1_dec_acc.sv
// Saturating decimal accumulator: acc = acc*10 + digit, clamped at 2^MAG_W-1.
module day1_dec_acc
    import day1_pkg::*;
#(
    parameter int unsigned MAG_W = MAG_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_zero,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output logic [MAG_W-1:0] acc,
    output logic             sat
);

    localparam int unsigned WW = MAG_W + 4;
    localparam logic [WW-1:0] MAX_W = {4'b0000, {MAG_W{1'b1}}};

    logic [MAG_W-1:0] acc_q, acc_d;
    logic [WW-1:0]    acc_w, prod_w;

    always_comb begin
        acc_w  = {4'b0000, acc_q};
        // x10 as x8 + x2; four guard bits hold the worst case (max*10 + 9)
        prod_w = (acc_w << 3) + (acc_w << 1) + {{(WW - 4){1'b0}}, digit};
        sat    = digit_valid && (prod_w > MAX_W);
        acc_d  = acc_q;
        if (load_zero) begin
            acc_d = '0;
        end else if (digit_valid) begin
            acc_d = sat ? {MAG_W{1'b1}} : prod_w[MAG_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/day1_stream_sequencer.sv
// Decodes an ASCII "L68\n"-style byte stream into direction/magnitude strobes for the dial
// datapath, and reports busy/done/error run status.
module day1_stream_sequencer
    import day1_pkg::*;
#(
    parameter int unsigned MAG_W = MAG_W_DEF,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             dp_clear,
    output logic             instruction_valid,
    output logic             direction,
    output logic [MAG_W-1:0] magnitude,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             overflow,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic             issue_q, issue_d;
    logic             dir_q, dir_d;
    logic             seen_q, seen_d;
    logic             overflow_q;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic             is_digit;
    logic             load_zero;
    logic             digit_valid;
    logic             acc_clear;
    logic             sat;
    logic [MAG_W-1:0] acc;

    assign accept    = in_valid & in_ready;
    assign is_digit  = (in_data >= CH_0) && (in_data <= CH_9);
    assign acc_clear = clear || (state_q == StClear);

    day1_dec_acc #(
        .MAG_W (MAG_W)
    ) u_dec_acc (
        .clock       (clock),
        .clear       (acc_clear),
        .load_zero   (load_zero),
        .digit_valid (digit_valid),
        .digit       (in_data[3:0]),
        .acc         (acc),
        .sat         (sat)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = 1'b0;
        dir_d       = dir_q;
        seen_d      = seen_q;
        load_zero   = 1'b0;
        digit_valid = 1'b0;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                dir_d   = 1'b0;
                seen_d  = 1'b0;
                state_d = StDir;
            end
            StDir: begin
                if (accept) begin
                    if (in_data == CH_L || in_data == CH_R) begin
                        dir_d     = (in_data == CH_R);
                        seen_d    = 1'b0;
                        load_zero = 1'b1;
                        state_d   = in_last ? StError : StNum;
                    end else if (in_data == CH_LF || in_data == CH_CR) begin
                        if (in_last) state_d = StDrain;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StNum: begin
                if (accept) begin
                    if (is_digit) begin
                        digit_valid = 1'b1;
                        seen_d      = 1'b1;
                        if (in_last) begin
                            issue_d = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (in_data == CH_CR) begin
                        if (in_last) state_d = StError;
                    end else if (in_data == CH_LF && seen_q) begin
                        issue_d = 1'b1;
                        state_d = in_last ? StDrain : StDir;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StDrain: begin
                // Hold through a pending final pulse so DRAIN follows it by a full cycle
                if (!issue_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            issue_q    <= 1'b0;
            dir_q      <= 1'b0;
            seen_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            issue_q <= issue_d;
            dir_q   <= dir_d;
            seen_q  <= seen_d;
            if (state_q == StClear) begin
                overflow_q <= 1'b0;
                count_q    <= '0;
            end else begin
                if (sat) overflow_q <= 1'b1;
                if (issue_d) count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        in_ready = (state_q == StDir) || (state_q == StNum);
        dp_clear = (state_q == StClear);
        busy     = (state_q == StClear) || (state_q == StDir) || (state_q == StNum) ||
                   (state_q == StDrain);
        done     = (state_q == StDone);
        error    = (state_q == StError);
    end

    // The accumulator is only zeroed after a pulse cycle, so it is the issued magnitude
    assign instruction_valid = issue_q;
    assign direction         = dir_q;
    assign magnitude         = acc;
    assign overflow          = overflow_q;
    assign instr_count       = count_q;

endmodule

// File: tb/tb_day1_stream_sequencer.sv
// Directed-vector bench with a pulse scoreboard for day1_stream_sequencer.
module tb_day1_stream_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, in_valid, in_last;
    logic [7:0]  in_data;
    logic        in_ready, dp_clear, instruction_valid, direction;
    logic [15:0] magnitude;
    logic        busy, done, error, overflow;
    logic [31:0] instr_count;

    int          checks = 0;
    int          failures = 0;
    int          clr_pulses = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;

    always #5 clock = ~clock;

    day1_stream_sequencer #(
        .MAG_W (16),
        .CNT_W (32)
    ) dut (
        .clock             (clock),
        .clear             (clear),
        .start             (start),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .dp_clear          (dp_clear),
        .instruction_valid (instruction_valid),
        .direction         (direction),
        .magnitude         (magnitude),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .overflow          (overflow),
        .instr_count       (instr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every strobe pops the oldest expected {direction, magnitude}
    always @(negedge clock) begin
        if (dp_clear) clr_pulses++;
        if (instruction_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual dir=%0d mag=%0d required none",
                         direction, magnitude);
            end else begin
                exp_v = exp_q.pop_front();
                check("pulse", {15'd0, direction, magnitude}, {15'd0, exp_v});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic d, input logic [15:0] m);
        exp_q.push_back({d, m});
    endtask

    task automatic do_start();
        clr_pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends s byte by byte; stops early once the DUT reports error
    task automatic send(input string s, input bit toggle, input bit use_last);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            if (error) break;
            if (toggle) begin
                in_valid = 1'b0;
                tick();
            end
            in_data  = s[i];
            in_valid = 1'b1;
            in_last  = use_last && (i == s.len() - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                tick();
                w++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout actual=0 required=1 byte=%0d", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                break;
            end
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Called just after the final byte's accepting edge
    task automatic finish_ok(input string tag, input int n, input bit ovf);
        @(negedge clock);
        check({tag, "_pulse_t1"}, {31'd0, instruction_valid}, 32'd1);
        check({tag, "_done_t1"}, {31'd0, done}, 32'd0);
        @(negedge clock);
        check({tag, "_drain_busy_t2"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_t2"}, {31'd0, done}, 32'd0);
        @(negedge clock);
        check({tag, "_done_t3"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_count"}, instr_count, n);
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf});
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_dp_clear_once"}, clr_pulses, 32'd1);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        tick();
    endtask

    task automatic finish_err(input string tag);
        tick();
        tick();
        @(negedge clock);
        check({tag, "_error"}, {31'd0, error}, 32'd1);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_count"}, instr_count, 32'd0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_dp_clear"}, {31'd0, dp_clear}, 32'd0);
        check({tag, "_ivalid"}, {31'd0, instruction_valid}, 32'd0);
        check({tag, "_dir"}, {31'd0, direction}, 32'd0);
        check({tag, "_mag"}, {16'd0, magnitude}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_count"}, instr_count, 32'd0);
    endtask

    initial begin
        clear    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        clear = 1'b0;
        @(negedge clock);
        check_all_zero("reset");
        tick();

        push(1'b0, 16'd68);
        push(1'b0, 16'd30);
        push(1'b1, 16'd48);
        do_start();
        send("L68\nL30\nR48\n", 1'b0, 1'b1);
        finish_ok("base", 3, 1'b0);

        push(1'b0, 16'd68);
        push(1'b0, 16'd30);
        push(1'b1, 16'd48);
        do_start();
        send("L68\015\nL30\015\nR48\015\n", 1'b1, 1'b1);
        finish_ok("crlf", 3, 1'b0);

        push(1'b1, 16'd5);
        do_start();
        send("R5", 1'b0, 1'b1);
        finish_ok("r5", 1, 1'b0);

        push(1'b1, 16'd65535);
        do_start();
        send("R70000\n", 1'b0, 1'b1);
        finish_ok("sat", 1, 1'b1);

        do_start();
        send("L\n", 1'b0, 1'b1);
        finish_err("nodigit");

        do_start();
        send("X3\n", 1'b0, 1'b1);
        finish_err("badletter");

        do_start();
        send("R1a\n", 1'b0, 1'b1);
        finish_err("baddigit");

        do_start();
        send("R123", 1'b0, 1'b0);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_all_zero("midclear");
        tick();

        push(1'b0, 16'd1);
        do_start();
        send("L1\n", 1'b0, 1'b1);
        finish_ok("after_clear", 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
